punc_mem_arbiter: RTL and testbench

PUNC_MEM_ARBITER -- requirements
Module: punc_mem_arbiter

---
 rtl/punc_mem_arbiter_if.sv | 45 ++++
 rtl/punc_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_punc_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_mem_arbiter_if.sv
// Bus bundle between the CPU, the program loader and one single-port memory.
// The master side is the environment (requesters plus memory); the slave side is the arbiter.
interface punc_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;

    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_lock;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [15:0] ldr_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Two-requester (CPU / loader) arbiter for one single-port memory.
// Each access takes ACCESS then RESP; arbitration happens only on edges leaving IDLE or RESP.
module punc_mem_arbiter #(
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    punc_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t      r_state;
    logic        r_last_ldr;
    logic        r_win_we;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_cpu_gnt;
    logic        r_ldr_gnt;
    logic        r_cpu_rvalid;
    logic        r_ldr_rvalid;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_ldr_rdata;
    logic        r_busy;

    state_t      w_state_nxt;
    logic        w_last_ldr_nxt;
    logic        w_win_we_nxt;
    logic        w_mem_en_nxt;
    logic        w_mem_we_nxt;
    logic [15:0] w_mem_addr_nxt;
    logic [15:0] w_mem_wdata_nxt;
    logic        w_cpu_gnt_nxt;
    logic        w_ldr_gnt_nxt;
    logic        w_cpu_rvalid_nxt;
    logic        w_ldr_rvalid_nxt;
    logic        w_cpu_ok;
    logic        w_ldr_ok;
    logic        w_pick_ldr;
    logic        w_cpu_rvalid;
    logic        w_ldr_rvalid;

    assign w_cpu_ok   = bus.cpu_req & ~bus.ldr_lock;
    assign w_ldr_ok   = bus.ldr_req;
    // The winner is also the new last-granted pointer, so r_last_ldr names the owner during ACCESS/RESP.
    assign w_pick_ldr = w_ldr_ok & (~w_cpu_ok | ((CPU_PRIO == 1'b0) & ~r_last_ldr));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
        w_state_nxt      = r_state;
        w_last_ldr_nxt   = r_last_ldr;
        w_win_we_nxt     = r_win_we;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_cpu_gnt_nxt    = 1'b0;
        w_ldr_gnt_nxt    = 1'b0;
        w_cpu_rvalid_nxt = 1'b0;
        w_ldr_rvalid_nxt = 1'b0;

        case (r_state)
            ST_ACCESS: begin
                w_state_nxt      = ST_RESP;
                w_cpu_rvalid_nxt = ~r_win_we & ~r_last_ldr;
                w_ldr_rvalid_nxt = ~r_win_we &  r_last_ldr;
            end
            default: begin
                if (w_cpu_ok | w_ldr_ok) begin
                    w_state_nxt     = ST_ACCESS;
                    w_last_ldr_nxt  = w_pick_ldr;
                    w_win_we_nxt    = w_pick_ldr ? bus.ldr_we    : bus.cpu_we;
                    w_mem_we_nxt    = w_pick_ldr ? bus.ldr_we    : bus.cpu_we;
                    w_mem_addr_nxt  = w_pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
                    w_mem_wdata_nxt = w_pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    w_mem_en_nxt    = 1'b1;
                    w_cpu_gnt_nxt   = ~w_pick_ldr;
                    w_ldr_gnt_nxt   = w_pick_ldr;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_ldr   <= 1'b1;
            r_win_we     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
            r_cpu_gnt    <= 1'b0;
            r_ldr_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_cpu_rdata  <= 16'h0000;
            r_ldr_rdata  <= 16'h0000;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_ldr   <= w_last_ldr_nxt;
            r_win_we     <= w_win_we_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_gnt    <= w_cpu_gnt_nxt;
            r_ldr_gnt    <= w_ldr_gnt_nxt;
            r_cpu_rvalid <= w_cpu_rvalid_nxt;
            r_ldr_rvalid <= w_ldr_rvalid_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            if (r_cpu_rvalid) r_cpu_rdata <= bus.mem_rdata;
            if (r_ldr_rvalid) r_ldr_rdata <= bus.mem_rdata;
        end
    end

    // Memory data only arrives during RESP, so it is forwarded then and held afterwards;
    // a reset raised inside RESP suppresses the response.
    assign w_cpu_rvalid = r_cpu_rvalid & ~rst;
    assign w_ldr_rvalid = r_ldr_rvalid & ~rst;

    assign bus.cpu_gnt    = r_cpu_gnt;
    assign bus.ldr_gnt    = r_ldr_gnt;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.ldr_rvalid = w_ldr_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
    assign bus.ldr_rdata  = w_ldr_rvalid ? bus.mem_rdata : r_ldr_rdata;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Two arbiter rigs (round-robin and CPU-priority), each with its own memory, requesters and
// a transaction-level reference model that predicts every output cycle by cycle.
module tb_punc_mem_arbiter;
    typedef enum logic [2:0] {M_IDLE, M_HOLD, M_LOCK, M_ONE, M_RAND} mode_t;

    logic  clk = 1'b0;
    logic  rst;
    mode_t mode;
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input int i);
        return (i == 0) ? 16'hBEEF : (16'(i * 257) ^ 16'h5A5A);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_rig
        punc_mem_arbiter_if u_if ();

        punc_mem_arbiter #(.CPU_PRIO(1'(g))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );

        // Synchronous memory: read data appears the cycle after mem_en.
        logic [15:0] mem [256];
        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            u_if.mem_rdata = 16'h0000;
            forever begin
                @(posedge clk);
                if (u_if.mem_en === 1'b1) begin
                    if (u_if.mem_we) mem[u_if.mem_addr[7:0]] <= u_if.mem_wdata;
                    else             u_if.mem_rdata <= mem[u_if.mem_addr[7:0]];
                end
            end
        end

        // Reference model: an issued access owns the memory for two cycles, then a new winner is chosen.
        logic [15:0] shadow [256];
        bit          m_last_ldr, m_pending, m_p_ldr, m_p_we;
        logic [15:0] m_p_data;
        bit          e_reset, e_mem_en, e_mem_we, e_cpu_gnt, e_ldr_gnt, e_busy, e_resp_cpu, e_resp_ldr;
        logic [15:0] e_addr, e_wdata, e_resp_data;
        initial begin
            bit cpu_ok, ldr_ok, pick_ldr;
            for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
            forever begin
                @(posedge clk);
                e_reset = 1'b0; e_mem_en = 1'b0; e_cpu_gnt = 1'b0; e_ldr_gnt = 1'b0;
                e_resp_cpu = 1'b0; e_resp_ldr = 1'b0;
                if (rst) begin
                    e_reset = 1'b1; e_busy = 1'b0; e_mem_we = 1'b0;
                    e_addr = 16'h0000; e_wdata = 16'h0000;
                    m_last_ldr = 1'b1; m_pending = 1'b0;
                end else if (m_pending) begin
                    m_pending = 1'b0;
                    e_busy    = 1'b1;
                    if (!m_p_we) begin
                        e_resp_cpu  = !m_p_ldr;
                        e_resp_ldr  = m_p_ldr;
                        e_resp_data = m_p_data;
                    end
                end else begin
                    cpu_ok = u_if.cpu_req && !u_if.ldr_lock;
                    ldr_ok = u_if.ldr_req;
                    e_busy = cpu_ok || ldr_ok;
                    if (e_busy) begin
                        if (cpu_ok && ldr_ok) pick_ldr = (g == 0) ? !m_last_ldr : 1'b0;
                        else                  pick_ldr = ldr_ok;
                        m_last_ldr = pick_ldr;
                        m_pending  = 1'b1;
                        m_p_ldr    = pick_ldr;
                        m_p_we     = pick_ldr ? u_if.ldr_we    : u_if.cpu_we;
                        e_addr     = pick_ldr ? u_if.ldr_addr  : u_if.cpu_addr;
                        e_wdata    = pick_ldr ? u_if.ldr_wdata : u_if.cpu_wdata;
                        e_mem_en   = 1'b1;
                        e_mem_we   = m_p_we;
                        e_cpu_gnt  = !pick_ldr;
                        e_ldr_gnt  = pick_ldr;
                        if (m_p_we) shadow[e_addr[7:0]] = e_wdata;
                        else        m_p_data = shadow[e_addr[7:0]];
                    end
                end
            end
        end

        // Compare on the falling edge, then drive the next requester inputs.
        logic [15:0] hold_cpu, hold_ldr;
        bit          fired;
        initial begin
            bit    exp_cv, exp_lv;
            string p;
            p = $sformatf("p%0d", g);
            hold_cpu = 16'h0000; hold_ldr = 16'h0000; fired = 1'b0;
            u_if.cpu_req = 1'b0; u_if.cpu_we = 1'b0; u_if.cpu_addr = 16'h0000; u_if.cpu_wdata = 16'h0000;
            u_if.ldr_req = 1'b0; u_if.ldr_we = 1'b0; u_if.ldr_addr = 16'h0000; u_if.ldr_wdata = 16'h0000;
            u_if.ldr_lock = 1'b0;
            forever begin
                @(negedge clk);
                if (e_reset) begin hold_cpu = 16'h0000; hold_ldr = 16'h0000; end
                exp_cv = e_resp_cpu && !rst;
                exp_lv = e_resp_ldr && !rst;
                check({p, ".busy"},       16'(u_if.busy),       16'(e_busy));
                check({p, ".mem_en"},     16'(u_if.mem_en),     16'(e_mem_en));
                check({p, ".cpu_gnt"},    16'(u_if.cpu_gnt),    16'(e_cpu_gnt));
                check({p, ".ldr_gnt"},    16'(u_if.ldr_gnt),    16'(e_ldr_gnt));
                check({p, ".cpu_rvalid"}, 16'(u_if.cpu_rvalid), 16'(exp_cv));
                check({p, ".ldr_rvalid"}, 16'(u_if.ldr_rvalid), 16'(exp_lv));
                if (e_mem_en || e_reset) begin
                    check({p, ".mem_we"},    16'(u_if.mem_we), 16'(e_mem_we));
                    check({p, ".mem_addr"},  u_if.mem_addr,    e_addr);
                    check({p, ".mem_wdata"}, u_if.mem_wdata,   e_wdata);
                end
                check({p, ".cpu_rdata"}, u_if.cpu_rdata, exp_cv ? e_resp_data : hold_cpu);
                check({p, ".ldr_rdata"}, u_if.ldr_rdata, exp_lv ? e_resp_data : hold_ldr);
                if (exp_cv) hold_cpu = e_resp_data;
                if (exp_lv) hold_ldr = e_resp_data;

                case (mode)
                    M_IDLE: begin
                        u_if.cpu_req = 1'b0; u_if.ldr_req = 1'b0; u_if.ldr_lock = 1'b0; fired = 1'b0;
                    end
                    M_HOLD: begin
                        u_if.ldr_lock = 1'b0;
                        if (e_cpu_gnt || !u_if.cpu_req) begin
                            u_if.cpu_req = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_addr = 16'($urandom);
                        end
                        if (e_ldr_gnt || !u_if.ldr_req) begin
                            u_if.ldr_req = 1'b1; u_if.ldr_we = 1'b0; u_if.ldr_addr = 16'($urandom);
                        end
                    end
                    M_LOCK: begin
                        u_if.ldr_lock = 1'b1;
                        u_if.cpu_req = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_addr = 16'h0020;
                        u_if.ldr_req = 1'b1; u_if.ldr_we = 1'b1;
                        u_if.ldr_addr = 16'h0010; u_if.ldr_wdata = 16'h1234;
                    end
                    M_ONE: begin
                        u_if.ldr_req = 1'b0; u_if.ldr_lock = 1'b0;
                        if (e_cpu_gnt) begin
                            u_if.cpu_req = 1'b0; fired = 1'b1;
                        end else if (!fired && !u_if.cpu_req) begin
                            u_if.cpu_req = 1'b1; u_if.cpu_we = 1'b0; u_if.cpu_addr = 16'h3000;
                        end
                    end
                    default: begin
                        if ($urandom_range(0, 9) == 0) u_if.ldr_lock = !u_if.ldr_lock;
                        if ((u_if.cpu_req && e_cpu_gnt && $urandom_range(0, 1) == 0) ||
                            (!u_if.cpu_req && $urandom_range(0, 2) == 0)) begin
                            u_if.cpu_req = 1'b1; u_if.cpu_we = 1'($urandom_range(0, 1));
                            u_if.cpu_addr = 16'($urandom); u_if.cpu_wdata = 16'($urandom);
                        end else if (e_cpu_gnt) begin
                            u_if.cpu_req = 1'b0;
                        end
                        if ((u_if.ldr_req && e_ldr_gnt && $urandom_range(0, 1) == 0) ||
                            (!u_if.ldr_req && $urandom_range(0, 2) == 0)) begin
                            u_if.ldr_req = 1'b1; u_if.ldr_we = 1'($urandom_range(0, 1));
                            u_if.ldr_addr = 16'($urandom); u_if.ldr_wdata = 16'($urandom);
                        end else if (e_ldr_gnt) begin
                            u_if.ldr_req = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Waits (bounded) for a CPU grant on rig 0; returns the number of cycles waited, 0 if none.
    task automatic wait_cpu_gnt(output int waited);
        waited = 0;
        for (int i = 1; i <= 12 && waited == 0; i++) begin
            @(posedge clk); #2;
            if (gen_rig[0].u_if.cpu_gnt === 1'b1) waited = i;
        end
    endtask

    initial begin
        int waited;
        rst  = 1'b1;
        mode = M_HOLD;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",   16'(gen_rig[0].u_if.busy),   16'h0000);
        check("rst_mem_en", 16'(gen_rig[0].u_if.mem_en), 16'h0000);
        rst = 1'b0;

        repeat (12) @(posedge clk);
        #2 mode = M_IDLE;
        repeat (14) @(posedge clk);
        #2 mode = M_LOCK;
        repeat (10) @(posedge clk);
        #2 mode = M_ONE;
        repeat (8) @(posedge clk);
        #2 mode = M_IDLE;
        repeat (4) @(posedge clk);

        // Lone CPU read of 0x3000: grant the cycle after the sampling edge, data one cycle later.
        #2 mode = M_ONE;
        wait_cpu_gnt(waited);
        check("one_latency", 16'(waited), 16'd1);
        check("one_addr",    gen_rig[0].u_if.mem_addr, 16'h3000);
        check("one_we",      16'(gen_rig[0].u_if.mem_we), 16'h0000);
        @(posedge clk); #2;
        check("one_rvalid",  16'(gen_rig[0].u_if.cpu_rvalid), 16'h0001);
        check("one_rdata",   gen_rig[0].u_if.cpu_rdata, 16'hBEEF);
        mode = M_IDLE;
        repeat (4) @(posedge clk);

        // Reset raised inside RESP of a read drops the response.
        #2 mode = M_ONE;
        wait_cpu_gnt(waited);
        check("drop_gnt_seen", 16'(waited != 0), 16'h0001);
        @(posedge clk); #1 rst = 1'b1;
        #1 check("drop_rvalid", 16'(gen_rig[0].u_if.cpu_rvalid), 16'h0000);
        @(posedge clk); #2;
        check("drop_busy",   16'(gen_rig[0].u_if.busy),   16'h0000);
        check("drop_mem_en", 16'(gen_rig[0].u_if.mem_en), 16'h0000);
        check("drop_rdata",  gen_rig[0].u_if.cpu_rdata,   16'h0000);
        check("drop_addr",   gen_rig[0].u_if.mem_addr,    16'h0000);
        rst  = 1'b0;
        mode = M_IDLE;
        repeat (4) @(posedge clk);

        #2 mode = M_RAND;
        repeat (3000) begin
            @(posedge clk); #2;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end
        rst  = 1'b0;
        mode = M_IDLE;
        repeat (6) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
